temp_sense_emu: RTL

TEMP_SENSE_EMU -- requirements
Module: temp_sense_emu

---
 rtl/temp_sense_pkg.sv | 24 ++
 rtl/temp_sense_emu_if.sv | 31 +++
 rtl/temp_sense_emu.sv | 104 ++++++++++
 3 files changed

// File: rtl/temp_sense_pkg.sv
// rtl/temp_sense_pkg.sv - shared types and constants for the temperature sensor emulator and its consumer
package temp_sense_pkg;

  // Conversion sequencer states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } temp_state_t;

  // Result codes are offset binary: code = temperature in C + 128.
  localparam logic [7:0] TempCodeOffset = 8'd128;

  // 25 C expressed as a code.
  localparam logic [7:0] DefaultResetCode = TempCodeOffset + 8'd25;

  // Convert a temperature in degrees C to its result code.
  function automatic logic [7:0] temp_to_code(input logic signed [8:0] temp_c);
    logic signed [8:0] sum;
    sum = temp_c + 9'sd128;
    return sum[7:0];
  endfunction

endpackage

// File: rtl/temp_sense_emu_if.sv
// rtl/temp_sense_emu_if.sv - sensor handshake and configuration bus between emulator and consumer
interface temp_sense_emu_if;

  logic        clr;
  logic [7:0]  tsdcalo;
  logic        tsdcaldone;
  logic        cfg_write;
  logic [15:0] cfg_writedata;
  logic [15:0] cfg_readdata;

  // Consumer side: drives clear and configuration writes, observes results.
  modport master (
    output clr,
    output cfg_write,
    output cfg_writedata,
    input  tsdcalo,
    input  tsdcaldone,
    input  cfg_readdata
  );

  // Emulator side.
  modport slave (
    input  clr,
    input  cfg_write,
    input  cfg_writedata,
    output tsdcalo,
    output tsdcaldone,
    output cfg_readdata
  );

endinterface

// File: rtl/temp_sense_emu.sv
// rtl/temp_sense_emu.sv - temperature sensor emulator; optional code ramp under TEMP_SENSE_EMU_RAMP_EN
module temp_sense_emu
  import temp_sense_pkg::*;
#(
  parameter logic [15:0] ConvCycles = 16'd16,
  parameter logic [7:0]  ResetCode  = DefaultResetCode
) (
  input  logic             clk,
  input  logic             reset,
  temp_sense_emu_if.slave  bus
);

  // A zero-length conversion has no meaning for the countdown below.
  if (ConvCycles < 16'd1) begin : g_conv_cycles_check
    $error("temp_sense_emu: ConvCycles must be >= 1");
  end

  temp_state_t state;
  logic [15:0] counter;
  logic [7:0]  code_q;
  logic        ramp_q;
  logic [6:0]  count_q;
  logic [7:0]  tsdcalo_q;
  logic        tsdcaldone_q;

`ifdef TEMP_SENSE_EMU_RAMP_EN
  logic [6:0] unused_wdata;
  assign unused_wdata = bus.cfg_writedata[15:9];
`else
  logic [7:0] unused_wdata;
  assign unused_wdata = bus.cfg_writedata[15:8];
`endif

  // Sequencer, configuration registers and registered outputs. The load
  // value of the countdown makes the CONVERT state last ConvCycles+1 cycles,
  // so tsdcaldone rises ConvCycles+1 edges after clr=0 is seen in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      counter      <= 16'd0;
      code_q       <= ResetCode;
      ramp_q       <= 1'b0;
      count_q      <= 7'd0;
      tsdcalo_q    <= ResetCode;
      tsdcaldone_q <= 1'b0;
    end else begin
      if (bus.cfg_write) begin
        code_q <= bus.cfg_writedata[7:0];
`ifdef TEMP_SENSE_EMU_RAMP_EN
        ramp_q <= bus.cfg_writedata[8];
`endif
      end

      case (state)
        IDLE: begin
          tsdcaldone_q <= 1'b0;
          if (!bus.clr) begin
            state   <= CONVERT;
            counter <= ConvCycles;
          end
        end

        CONVERT: begin
          if (bus.clr) begin
            // Abort wins over completion; nothing is published or counted.
            state <= IDLE;
          end else if (counter == 16'd0) begin
            state        <= DONE;
            // code_q here is the pre-write value, so a same-edge write
            // only affects the following conversion.
            tsdcalo_q    <= code_q;
            tsdcaldone_q <= 1'b1;
            count_q      <= count_q + 7'd1;
`ifdef TEMP_SENSE_EMU_RAMP_EN
            if (ramp_q && !bus.cfg_write && (code_q != 8'hFF)) begin
              code_q <= code_q + 8'd1;
            end
`endif
          end else begin
            counter <= counter - 16'd1;
          end
        end

        DONE: begin
          // Result holds until the consumer clears; no automatic restart.
          if (bus.clr) begin
            state        <= IDLE;
            tsdcaldone_q <= 1'b0;
          end
        end

        default: begin
          state        <= IDLE;
          tsdcaldone_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tsdcalo      = tsdcalo_q;
  assign bus.tsdcaldone   = tsdcaldone_q;
  assign bus.cfg_readdata = {count_q, ramp_q, code_q};

endmodule
